apb_master_arbiter: RTL

//  Shares one APB master interface block among NUM_REQ requesters. Sits between

---
 rtl/apb_master_arbiter_if.sv | 66 ++++++
 rtl/apb_master_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_arbiter_if
//  Purpose  : Bundles the requester-side and APB-master-side signals of the
//             apb_master_arbiter into one interface.
//             modport slave  : the arbiter's view (requests in, completions out,
//                              command out to the APB master block).
//             modport master : the environment's view (requesters plus the
//                              APB master block), directions reversed.
//  Ports    : req_sel/addr/write/wdata/error_in  requester commands (packed)
//             req_lock_in                         per-requester lock (APB_ARB_LOCK_EN)
//             req_ready/error_out, req_rdata_out  completion back to grantee
//             grant_out                           one-hot current grant
//             mst_sel/addr/write/wdata/error_out  command to APB master
//             mst_ready/error/rdata_in            status from APB master
//  Config   : APB_ARB_LOCK_EN adds req_lock_in.
//  Revision : 1.0  initial release
// ============================================================================
interface apb_master_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                req_sel_in;
  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr_in;
  logic [NUM_REQ-1:0]                req_write_in;
  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata_in;
  logic [NUM_REQ-1:0]                req_error_in;
`ifdef APB_ARB_LOCK_EN
  logic [NUM_REQ-1:0]                req_lock_in;
`endif
  logic [NUM_REQ-1:0]                req_ready_out;
  logic [NUM_REQ-1:0]                req_error_out;
  logic [APB_DATA_WIDTH-1:0]         req_rdata_out;
  logic [NUM_REQ-1:0]                grant_out;

  logic                              mst_sel_out;
  logic [APB_ADDR_WIDTH-1:0]         mst_addr_out;
  logic                              mst_write_out;
  logic [APB_DATA_WIDTH-1:0]         mst_wdata_out;
  logic                              mst_error_out;
  logic                              mst_ready_in;
  logic                              mst_error_in;
  logic [APB_DATA_WIDTH-1:0]         mst_rdata_in;

  modport slave (
`ifdef APB_ARB_LOCK_EN
    input  req_lock_in,
`endif
    input  req_sel_in, req_addr_in, req_write_in, req_wdata_in, req_error_in,
    output req_ready_out, req_error_out, req_rdata_out, grant_out,
    output mst_sel_out, mst_addr_out, mst_write_out, mst_wdata_out, mst_error_out,
    input  mst_ready_in, mst_error_in, mst_rdata_in
  );

  modport master (
`ifdef APB_ARB_LOCK_EN
    output req_lock_in,
`endif
    output req_sel_in, req_addr_in, req_write_in, req_wdata_in, req_error_in,
    input  req_ready_out, req_error_out, req_rdata_out, grant_out,
    input  mst_sel_out, mst_addr_out, mst_write_out, mst_wdata_out, mst_error_out,
    output mst_ready_in, mst_error_in, mst_rdata_in
  );
endinterface
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_arbiter
//  Purpose  : Round-robin arbiter sharing one APB master block among NUM_REQ
//             requesters. Grants one requester, registers its command, drives
//             it to the master, returns the completion to the grantee and
//             re-arbitrates. A watchdog aborts transfers the master never ends.
//  Ports    : apb_clk_in   clock, all logic on rising edge
//             apb_rstn_in  asynchronous active-low reset
//             bus          apb_master_arbiter_if.slave (requester + master side)
//  Config   : APB_ARB_LOCK_EN - when defined, a grantee holding req_lock_in
//             and req_sel_in at completion is re-granted without rotation.
//  Revision : 1.0  initial release
// ============================================================================
module apb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int WATCHDOG_CYCLE = 16
) (
  input  logic                 apb_clk_in,
  input  logic                 apb_rstn_in,
  apb_master_arbiter_if.slave  bus
);

  localparam int c_IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_WD_W = $clog2(WATCHDOG_CYCLE + 1);
  localparam logic [c_IW-1:0]    c_PTR_RST = c_IW'(NUM_REQ - 1);
  localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(WATCHDOG_CYCLE - 1);
  localparam logic [NUM_REQ-1:0] c_ONE     = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [c_IW-1:0]           r_ptr;
  logic [c_IW-1:0]           r_gidx;
  logic [NUM_REQ-1:0]        r_grant;
  logic                      r_sel;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic                      r_write;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic [c_WD_W-1:0]         r_wdog;
  logic [NUM_REQ-1:0]        r_ready;
  logic [NUM_REQ-1:0]        r_err;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
`ifdef APB_ARB_LOCK_EN
  logic                      r_lock_hold;
`endif

  // Per-requester views of the packed command buses
  logic [APB_ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
  logic [APB_DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_addr_arr[i]  = bus.req_addr_in[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
    assign w_wdata_arr[i] = bus.req_wdata_in[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
  end

  // (p + k) mod NUM_REQ for 1 <= k <= NUM_REQ without a general divider
  function automatic logic [c_IW-1:0] f_wrap(input logic [c_IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return c_IW'(s);
  endfunction

  // Round-robin pick: first requester after the last grantee
  logic            w_found;
  logic [c_IW-1:0] w_pick;

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && bus.req_sel_in[f_wrap(r_ptr, k)]) begin
        w_found = 1'b1;
        w_pick  = f_wrap(r_ptr, k);
      end
    end
  end

  // A new grant is started from IDLE, or (lock build) straight from RELEASE
  // back to the same grantee once the master has dropped its ready.
  logic            w_do_start;
  logic [c_IW-1:0] w_start_idx;

  always_comb begin
    w_do_start  = (r_state == ST_IDLE) && w_found;
    w_start_idx = w_pick;
`ifdef APB_ARB_LOCK_EN
    if (r_state == ST_RELEASE) begin
      w_do_start  = !bus.mst_ready_in && r_lock_hold;
      w_start_idx = r_gidx;
    end
`endif
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      r_state     <= ST_IDLE;
      r_ptr       <= c_PTR_RST;
      r_gidx      <= '0;
      r_grant     <= '0;
      r_sel       <= 1'b0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_wdog      <= '0;
      r_ready     <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
`ifdef APB_ARB_LOCK_EN
      r_lock_hold <= 1'b0;
`endif
    end else begin
      r_ready <= '0;
      if (w_do_start) begin
        r_state <= ST_BUSY;
        r_gidx  <= w_start_idx;
        r_ptr   <= w_start_idx;   // unchanged on a locked re-grant
        r_grant <= c_ONE << w_start_idx;
        r_sel   <= 1'b1;
        r_addr  <= w_addr_arr[w_start_idx];
        r_write <= bus.req_write_in[w_start_idx];
        r_wdata <= bus.req_write_in[w_start_idx] ? w_wdata_arr[w_start_idx] : '0;
        r_wdog  <= '0;
      end else begin
        case (r_state)
          ST_BUSY: begin
            // Real completion takes priority over a coincident watchdog expiry
            if (bus.mst_ready_in || (r_wdog == c_WD_LAST)) begin
              r_ready <= r_grant;
              r_err   <= bus.mst_ready_in ? (r_grant & {NUM_REQ{bus.mst_error_in}})
                                          : r_grant;
              r_rdata <= bus.mst_ready_in ? bus.mst_rdata_in : '0;
              r_state <= ST_RELEASE;
              r_grant <= '0;
              r_sel   <= 1'b0;
              r_addr  <= '0;
              r_write <= 1'b0;
              r_wdata <= '0;
`ifdef APB_ARB_LOCK_EN
              r_lock_hold <= bus.req_lock_in[r_gidx] & bus.req_sel_in[r_gidx];
`endif
            end else begin
              r_wdog <= r_wdog + 1'b1;
            end
          end
          ST_RELEASE: begin
            // Wait for the master to drop ready so it is back in its idle state
            if (!bus.mst_ready_in) begin
              r_state <= ST_IDLE;
            end
          end
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.grant_out     = r_grant;
  assign bus.req_ready_out = r_ready;
  assign bus.req_error_out = r_err;
  assign bus.req_rdata_out = r_rdata;
  assign bus.mst_sel_out   = r_sel;
  assign bus.mst_addr_out  = r_addr;
  assign bus.mst_write_out = r_write;
  assign bus.mst_wdata_out = r_wdata;
  // Requester-side error passes straight through while a transfer is active
  assign bus.mst_error_out = r_sel & bus.req_error_in[r_gidx];

endmodule
`default_nettype wire
